// File: rtl/pkt_forward_if.sv
// Handshake bundle for pkt_forward.
//   FIFO side  : fifo_ready/fifo_dout in, fifo_pop out.
//   Output side: out_valid/out_data/out_port/out_sop/out_eop out, out_ready in.
// modport master is the forwarding stage; modport slave is the surrounding
// FIFO + crossbar environment.
interface pkt_forward_if #(
  parameter int WIDTH = 32,
  parameter int PW    = 2
);
  logic             fifo_ready;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_pop;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [PW-1:0]    out_port;
  logic             out_sop;
  logic             out_eop;
  logic             out_ready;

  modport master (
    input  fifo_ready, fifo_dout, out_ready,
    output fifo_pop, out_valid, out_data, out_port, out_sop, out_eop
  );

  modport slave (
    output fifo_ready, fifo_dout, out_ready,
    input  fifo_pop, out_valid, out_data, out_port, out_sop, out_eop
  );
endinterface

// File: rtl/pkt_forward.sv
// pkt_forward: pops header+payload packets from the router input FIFO,
// forwards legal packets to a registered valid/ready output tagged with the
// destination port, and silently discards illegal ones.
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous active-high reset
//   bus       pkt_forward_if.master (FIFO pop side + registered output side)
//   pkt_cnt   forwarded packets, saturating
//   drop_cnt  dropped packets, saturating
//   busy      high while inside a packet (not awaiting a header)
// Header word: [31:24] dest, [23:8] reserved, [7:0] payload length.
module pkt_forward #(
  parameter int WIDTH  = 32,
  parameter int NPORTS = 4,
  parameter int PW     = 2,
  parameter int MAXLEN = 64
) (
  input  logic          clock,
  input  logic          reset,
  pkt_forward_if.master bus,
  output logic [15:0]   pkt_cnt,
  output logic [15:0]   drop_cnt,
  output logic          busy
);

  localparam logic [7:0] NPORTS_W = 8'(NPORTS);
  localparam logic [7:0] MAXLEN_W = 8'(MAXLEN);

  typedef enum logic [1:0] {S_HDR, S_PAY, S_DROP} state_t;

  state_t           state_q, state_d;
  logic [7:0]       rem_q, rem_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [PW-1:0]    out_port_q, out_port_d;
  logic             out_sop_q, out_sop_d;
  logic             out_eop_q, out_eop_d;
  logic [15:0]      pkt_cnt_q, pkt_cnt_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic [7:0] hdr_dest;
  logic [7:0] hdr_len;
  logic       hdr_legal;
  logic       load;
  logic       pop;

  assign hdr_dest  = bus.fifo_dout[31:24];
  assign hdr_len   = bus.fifo_dout[7:0];
  assign hdr_legal = (hdr_dest < NPORTS_W) && (hdr_len <= MAXLEN_W);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_HDR;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_port_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_port_q  <= out_port_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Output logic: pop decision. Illegal headers and dropped payload are
  // consumed regardless of output backpressure.
  always_comb begin
    load = !out_valid_q || bus.out_ready;
    pop  = 1'b0;
    if (bus.fifo_ready && !reset) begin
      case (state_q)
        S_HDR:   pop = hdr_legal ? load : 1'b1;
        S_PAY:   pop = load;
        S_DROP:  pop = 1'b1;
        default: pop = 1'b0;
      endcase
    end
    busy = (state_q != S_HDR);
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_data_d  = out_data_q;
    out_port_d  = out_port_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    pkt_cnt_d   = pkt_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (pop) begin
      case (state_q)
        S_HDR: begin
          rem_d = hdr_len;
          if (hdr_legal) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.fifo_dout;
            out_port_d  = hdr_dest[PW-1:0];
            out_sop_d   = 1'b1;
            out_eop_d   = (hdr_len == 8'd0);
            pkt_cnt_d   = (pkt_cnt_q == '1) ? pkt_cnt_q : pkt_cnt_q + 16'd1;
            state_d     = (hdr_len != 8'd0) ? S_PAY : S_HDR;
          end else begin
            drop_cnt_d  = (drop_cnt_q == '1) ? drop_cnt_q : drop_cnt_q + 16'd1;
            state_d     = (hdr_len != 8'd0) ? S_DROP : S_HDR;
          end
        end
        S_PAY: begin
          out_valid_d = 1'b1;
          out_data_d  = bus.fifo_dout;
          out_sop_d   = 1'b0;
          out_eop_d   = (rem_q == 8'd1);
          rem_d       = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = S_HDR;
        end
        S_DROP: begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = S_HDR;
        end
        default: state_d = S_HDR;
      endcase
    end
  end

  assign bus.fifo_pop  = pop;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_port  = out_port_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_pkt_forward.sv
module tb_pkt_forward;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  port;
    logic        sop;
    logic        eop;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;
  logic        busy;

  pkt_forward_if #(.WIDTH(32), .PW(2)) bus ();

  pkt_forward #(.WIDTH(32), .NPORTS(4), .PW(2), .MAXLEN(64)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus.master),
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  logic [31:0] fifo_q[$];
  exp_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          acc_first = 0;
  int          acc_last = 0;
  bit          full_rate = 0;
  int unsigned exp_pkt = 0;
  int unsigned exp_drop = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: legal packets appear whole and in order; illegal ones vanish.
  task automatic push_pkt(input logic [7:0] dest, input logic [7:0] len, input logic [15:0] rsv);
    logic [31:0] w;
    exp_t        e;
    bit          legal;
    legal = (dest < 8'd4) && (len <= 8'd64);
    w = {dest, rsv, len};
    fifo_q.push_back(w);
    if (legal) begin
      e.data = w; e.port = dest[1:0]; e.sop = 1'b1; e.eop = (len == 8'd0);
      exp_q.push_back(e);
    end
    for (int i = 0; i < int'(len); i++) begin
      w = $urandom;
      fifo_q.push_back(w);
      if (legal) begin
        e.data = w; e.port = dest[1:0]; e.sop = 1'b0; e.eop = (i == int'(len) - 1);
        exp_q.push_back(e);
      end
    end
    if (legal) exp_pkt = (exp_pkt < 65535) ? exp_pkt + 1 : exp_pkt;
    else       exp_drop = (exp_drop < 65535) ? exp_drop + 1 : exp_drop;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || bus.out_valid) && n < 20000) begin
      @(negedge clock); #3;
      n++;
    end
    chk({name, "_drain_timeout"}, 64'(n >= 20000), 64'd0);
    repeat (2) @(negedge clock);
    #3;
  endtask

  // FIFO model + out_ready driver
  initial begin
    bit pop_seen;
    bus.fifo_ready = 1'b0;
    bus.fifo_dout  = '0;
    bus.out_ready  = 1'b0;
    forever begin
      @(negedge clock);
      if (fifo_q.size() > 0 && (full_rate || $urandom_range(0, 3) != 0)) begin
        bus.fifo_ready = 1'b1;
        bus.fifo_dout  = fifo_q[0];
      end else begin
        bus.fifo_ready = 1'b0;
        bus.fifo_dout  = $urandom;
      end
      bus.out_ready = full_rate ? 1'b1 : ($urandom_range(0, 2) != 0);
      #1;
      pop_seen = bus.fifo_pop;
      if (!bus.fifo_ready) chk("pop_without_ready", 64'(pop_seen), 64'd0);
      @(posedge clock);
      if (pop_seen && !reset && fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
  end

  // Output monitor / scoreboard
  initial begin
    bit          stalled;
    logic [36:0] held;
    exp_t        e;
    stalled = 0;
    held = '0;
    forever begin
      @(negedge clock); #2;
      if (reset) begin
        stalled = 0;
      end else begin
        if (stalled)
          chk("stall_hold", 64'({bus.out_valid, bus.out_data, bus.out_port, bus.out_sop, bus.out_eop}),
              64'(held));
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 64'({bus.out_data, bus.out_port, bus.out_sop, bus.out_eop}), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("out_word", 64'({bus.out_data, bus.out_port, bus.out_sop, bus.out_eop}), 64'(e));
          end
          if (acc_cnt == 0) acc_first = cyc;
          acc_last = cyc;
          acc_cnt++;
          stalled = 0;
        end else if (bus.out_valid) begin
          stalled = 1;
          held = {bus.out_valid, bus.out_data, bus.out_port, bus.out_sop, bus.out_eop};
        end else begin
          stalled = 0;
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    // T1: async reset values, before any clock edge
    chk("t1_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t1_fifo_pop", 64'(bus.fifo_pop), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("t1_drop_cnt", 64'(drop_cnt), 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // T2: full-rate 4-word packet, no bubbles
    full_rate = 1;
    acc_cnt = 0;
    push_pkt(8'h02, 8'd3, 16'h0000);
    drain("t2");
    chk("t2_words", 64'(acc_cnt), 64'd4);
    chk("t2_burst_span", 64'(acc_last - acc_first), 64'd3);
    chk("t2_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));

    // T3: same packet with random backpressure and FIFO gaps
    full_rate = 0;
    push_pkt(8'h02, 8'd3, 16'h0000);
    drain("t3");
    chk("t3_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));

    // T4: illegal dest, len=65 drop; len=64 and dest=3 are legal boundaries
    push_pkt(8'h07, 8'd2, 16'h0000);
    push_pkt(8'h01, 8'd65, 16'h1234);
    push_pkt(8'h04, 8'd0, 16'h0000);
    push_pkt(8'h03, 8'd64, 16'hBEEF);
    drain("t4");
    chk("t4_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    chk("t4_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));

    // T5: zero-length packet then 2-word packet back-to-back
    full_rate = 1;
    acc_cnt = 0;
    push_pkt(8'h01, 8'd0, 16'h0000);
    push_pkt(8'h03, 8'd1, 16'h0000);
    drain("t5");
    chk("t5_words", 64'(acc_cnt), 64'd3);
    chk("t5_burst_span", 64'(acc_last - acc_first), 64'd2);

    // Randomized traffic
    full_rate = 0;
    for (int p = 0; p < 40; p++) begin
      logic [7:0] d;
      logic [7:0] l;
      d = 8'($urandom_range(0, 5));
      case ($urandom_range(0, 5))
        0: l = 8'd0;
        1: l = 8'd1;
        2: l = 8'd64;
        3: l = 8'd65;
        default: l = 8'($urandom_range(0, 20));
      endcase
      push_pkt(d, l, 16'($urandom));
    end
    drain("rand");
    chk("rand_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
    chk("rand_drop_cnt", 64'(drop_cnt), 64'(exp_drop));

    // T6: reset in the middle of a packet
    full_rate = 1;
    acc_cnt = 0;
    push_pkt(8'h01, 8'd8, 16'h0000);
    n = 0;
    while (acc_cnt < 3 && n < 200) begin
      @(negedge clock); #3;
      n++;
    end
    chk("t6_wait_timeout", 64'(n >= 200), 64'd0);
    chk("t6_busy_mid", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("t6_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_fifo_pop", 64'(bus.fifo_pop), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_pkt_cnt", 64'(pkt_cnt), 64'd0);
    fifo_q.delete();
    exp_q.delete();
    exp_pkt = 0;
    exp_drop = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    acc_cnt = 0;
    push_pkt(8'h02, 8'd2, 16'h5A5A);
    drain("t6_post");
    chk("t6_post_words", 64'(acc_cnt), 64'd3);
    chk("t6_post_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
